// File: rtl/fp32_mul_pipe.sv
// rtl/fp32_mul_pipe.sv - pipelined binary32 multiplier, RNE rounding, flush-to-zero
`timescale 1ns/1ps

module fp32_mul_pipe #(
    parameter int          OUT_REG = 1,
    parameter logic [31:0] QNAN    = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        val,
    input  logic        over,
    output logic [31:0] y,
    output logic        out_val,
    output logic        out_over,
    output logic        f_invalid,
    output logic        f_ovf,
    output logic        f_unf,
    output logic        f_inexact
);

    localparam int LAT = 3 + OUT_REG;

    // ---------------------------------------------------------------
    // Stage 1: unpack, classify, exponent sum, mantissa product
    // ---------------------------------------------------------------
    logic [7:0]  e1, e2;
    logic [22:0] f1, f2;
    logic        zero1, zero2, inf1, inf2, nan1, nan2, snan1, snan2;
    logic        sign_d;

    assign e1     = x1[30:23];
    assign e2     = x2[30:23];
    assign f1     = x1[22:0];
    assign f2     = x2[22:0];
    // Denormals share the zero class: they are flushed before any arithmetic.
    assign zero1  = (e1 == 8'd0);
    assign zero2  = (e2 == 8'd0);
    assign inf1   = (e1 == 8'hFF) && (f1 == 23'd0);
    assign inf2   = (e2 == 8'hFF) && (f2 == 23'd0);
    assign nan1   = (e1 == 8'hFF) && (f1 != 23'd0);
    assign nan2   = (e2 == 8'hFF) && (f2 != 23'd0);
    assign snan1  = nan1 & ~f1[22];
    assign snan2  = nan2 & ~f2[22];
    assign sign_d = x1[31] ^ x2[31];

    logic               s1_spec_d;
    logic [31:0]        s1_spec_y_d;
    logic               s1_spec_inv_d;
    logic signed [9:0]  s1_esum_d;
    logic [47:0]        s1_prod_d;

    assign s1_esum_d = $signed({2'b00, e1}) + $signed({2'b00, e2}) - 10'sd127;
    assign s1_prod_d = {24'd0, 1'b1, f1} * {24'd0, 1'b1, f2};

    // Special-operand result, in priority order; it overrides the datapath later.
    always_comb begin
        s1_spec_d     = 1'b0;
        s1_spec_y_d   = 32'd0;
        s1_spec_inv_d = 1'b0;
        if (nan1 || nan2) begin
            s1_spec_d     = 1'b1;
            s1_spec_y_d   = QNAN;
            s1_spec_inv_d = snan1 | snan2;
        end else if ((inf1 && zero2) || (inf2 && zero1)) begin
            s1_spec_d     = 1'b1;
            s1_spec_y_d   = QNAN;
            s1_spec_inv_d = 1'b1;
        end else if (inf1 || inf2) begin
            s1_spec_d     = 1'b1;
            s1_spec_y_d   = {sign_d, 8'hFF, 23'd0};
        end else if (zero1 || zero2) begin
            s1_spec_d     = 1'b1;
            s1_spec_y_d   = {sign_d, 31'd0};
        end
    end

    logic               s1_val_q;
    logic               s1_sign_q;
    logic               s1_spec_q;
    logic [31:0]        s1_spec_y_q;
    logic               s1_spec_inv_q;
    logic signed [9:0]  s1_esum_q;
    logic [47:0]        s1_prod_q;

    // Stage 1 register; data only loads with a valid pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_val_q <= 1'b0;
        end else begin
            s1_val_q <= val;
        end
        if (val) begin
            s1_sign_q     <= sign_d;
            s1_spec_q     <= s1_spec_d;
            s1_spec_y_q   <= s1_spec_y_d;
            s1_spec_inv_q <= s1_spec_inv_d;
            s1_esum_q     <= s1_esum_d;
            s1_prod_q     <= s1_prod_d;
        end
    end

    // ---------------------------------------------------------------
    // Stage 2: normalise product to 1.xxx, extract guard and sticky
    // ---------------------------------------------------------------
    logic [23:0]        s2_mant_d;
    logic               s2_g_d;
    logic               s2_s_d;
    logic signed [9:0]  s2_exp_d;

    // Product of two 1.x mantissas lies in [1,4); at most one right shift.
    always_comb begin
        s2_mant_d = s1_prod_q[46:23];
        s2_g_d    = s1_prod_q[22];
        s2_s_d    = |s1_prod_q[21:0];
        s2_exp_d  = s1_esum_q;
        if (s1_prod_q[47]) begin
            s2_mant_d = s1_prod_q[47:24];
            s2_g_d    = s1_prod_q[23];
            s2_s_d    = |s1_prod_q[22:0];
            s2_exp_d  = s1_esum_q + 10'sd1;
        end
    end

    logic               s2_val_q;
    logic               s2_sign_q;
    logic               s2_spec_q;
    logic [31:0]        s2_spec_y_q;
    logic               s2_spec_inv_q;
    logic [23:0]        s2_mant_q;
    logic               s2_g_q;
    logic               s2_s_q;
    logic signed [9:0]  s2_exp_q;

    // Stage 2 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_val_q <= 1'b0;
        end else begin
            s2_val_q <= s1_val_q;
        end
        if (s1_val_q) begin
            s2_sign_q     <= s1_sign_q;
            s2_spec_q     <= s1_spec_q;
            s2_spec_y_q   <= s1_spec_y_q;
            s2_spec_inv_q <= s1_spec_inv_q;
            s2_mant_q     <= s2_mant_d;
            s2_g_q        <= s2_g_d;
            s2_s_q        <= s2_s_d;
            s2_exp_q      <= s2_exp_d;
        end
    end

    // ---------------------------------------------------------------
    // Stage 3: round to nearest even, range check, special override
    // ---------------------------------------------------------------
    logic               round_up;
    logic [24:0]        mant_r;
    logic               carry;
    logic signed [9:0]  exp_f;
    logic [22:0]        frac_f;
    logic [31:0]        r_y_d;
    logic [3:0]         r_f_d;

    assign round_up = s2_g_q & (s2_s_q | s2_mant_q[0]);
    assign mant_r   = {1'b0, s2_mant_q} + {24'd0, round_up};
    assign carry    = mant_r[24];
    assign exp_f    = s2_exp_q + (carry ? 10'sd1 : 10'sd0);
    assign frac_f   = carry ? mant_r[23:1] : mant_r[22:0];

    // Final result and flags {invalid, ovf, unf, inexact}.
    always_comb begin
        r_y_d = {s2_sign_q, exp_f[7:0], frac_f};
        r_f_d = {3'b000, s2_g_q | s2_s_q};
        if (s2_spec_q) begin
            r_y_d = s2_spec_y_q;
            r_f_d = {s2_spec_inv_q, 3'b000};
        end else if (exp_f >= 10'sd255) begin
            r_y_d = {s2_sign_q, 8'hFF, 23'd0};
            r_f_d = 4'b0101;
        end else if (exp_f <= 10'sd0) begin
            r_y_d = {s2_sign_q, 31'd0};
            r_f_d = 4'b0011;
        end
    end

    logic        r_val_q;
    logic [31:0] r_y_q;
    logic [3:0]  r_f_q;

    // Stage 3 register; result and flags hold between valid pairs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val_q <= 1'b0;
            r_y_q   <= 32'd0;
            r_f_q   <= 4'd0;
        end else begin
            r_val_q <= s2_val_q;
            if (s2_val_q) begin
                r_y_q <= r_y_d;
                r_f_q <= r_f_d;
            end
        end
    end

    // ---------------------------------------------------------------
    // Optional output register
    // ---------------------------------------------------------------
    logic [3:0] out_f;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic        o_val_q;
            logic [31:0] o_y_q;
            logic [3:0]  o_f_q;

            // Extra retiming stage, same hold behaviour as stage 3.
            always_ff @(posedge clk) begin
                if (rst) begin
                    o_val_q <= 1'b0;
                    o_y_q   <= 32'd0;
                    o_f_q   <= 4'd0;
                end else begin
                    o_val_q <= r_val_q;
                    if (r_val_q) begin
                        o_y_q <= r_y_q;
                        o_f_q <= r_f_q;
                    end
                end
            end

            assign out_val = o_val_q;
            assign y       = o_y_q;
            assign out_f   = o_f_q;
        end else begin : g_no_out_reg
            assign out_val = r_val_q;
            assign y       = r_y_q;
            assign out_f   = r_f_q;
        end
    endgenerate

    assign f_invalid = out_f[3];
    assign f_ovf     = out_f[2];
    assign f_unf     = out_f[1];
    assign f_inexact = out_f[0];

    // ---------------------------------------------------------------
    // End-of-run marker: same latency as data, sticky until reset
    // ---------------------------------------------------------------
    logic [LAT-2:0] over_sr_q;
    logic           out_over_q;

    // over runs alongside the data pipe regardless of val.
    always_ff @(posedge clk) begin
        if (rst) begin
            over_sr_q  <= '0;
            out_over_q <= 1'b0;
        end else begin
            over_sr_q  <= {over_sr_q[LAT-3:0], over};
            out_over_q <= out_over_q | over_sr_q[LAT-2];
        end
    end

    assign out_over = out_over_q;

endmodule

// File: tb/tb_fp32_mul_pipe.sv
// tb/tb_fp32_mul_pipe.sv - self-checking bench for fp32_mul_pipe
`timescale 1ns/1ps

module tb_fp32_mul_pipe;

    localparam int          L  = 4;
    localparam logic [31:0] QN = 32'h7FC00000;

    logic        clk = 1'b0;
    logic        rst, val, over;
    logic [31:0] x1, x2, y;
    logic        out_val, out_over, f_invalid, f_ovf, f_unf, f_inexact;

    int checks = 0;
    int errors = 0;

    fp32_mul_pipe #(.OUT_REG(1), .QNAN(QN)) dut (
        .clk(clk), .rst(rst), .x1(x1), .x2(x2), .val(val), .over(over),
        .y(y), .out_val(out_val), .out_over(out_over),
        .f_invalid(f_invalid), .f_ovf(f_ovf), .f_unf(f_unf), .f_inexact(f_inexact)
    );

    always #5 clk = ~clk;

    logic [31:0] sa [256];
    logic [31:0] sb [256];
    logic [31:0] ey [256];
    logic [3:0]  ef [256];
    logic        sv [256];
    int          n = 0;
    logic [31:0] hold_y;
    logic [3:0]  hold_f;
    logic        ov_exp;

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Reference: exact integer product, rounded by comparing the discarded part with one half ulp.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        int          ea, eb, msb, sh, e;
        logic        s, za, zb, ia, ib, na, nb, sna, snb, inx;
        logic [63:0] p, q, rem, half;
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        s   = a[31] ^ b[31];
        za  = (ea == 0);
        zb  = (eb == 0);
        ia  = (ea == 255) && (a[22:0] == 0);
        ib  = (eb == 255) && (b[22:0] == 0);
        na  = (ea == 255) && (a[22:0] != 0);
        nb  = (eb == 255) && (b[22:0] != 0);
        sna = na && !a[22];
        snb = nb && !b[22];
        if (na || nb)                  return {sna | snb, 3'b000, QN};
        if ((ia && zb) || (ib && za))  return {4'b1000, QN};
        if (ia || ib)                  return {4'b0000, s, 8'hFF, 23'd0};
        if (za || zb)                  return {4'b0000, s, 31'd0};
        p   = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
        msb = 63;
        while (p[msb] == 1'b0) msb--;
        sh   = msb - 23;
        q    = p >> sh;
        rem  = p & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        inx  = (rem != 0);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        e = ea + eb - 127 + (msb - 46);
        if (q == 64'h1000000) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, inx, s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_normal(input int lo, input int hi);
        logic [31:0] r;
        logic [7:0]  e;
        r = $urandom();
        e = 8'($urandom_range(hi, lo));
        return {r[31], e, r[22:0]};
    endfunction

    function automatic logic [31:0] rnd_any();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(9, 0))
            0:       return {r[31], 31'd0};
            1:       return {r[31], 8'd0, r[22:1], 1'b1};
            2:       return {r[31], 8'hFF, 23'd0};
            3:       return {r[31], 8'hFF, 1'b1, r[21:0]};
            4:       return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
            default: return rnd_normal(1, 254);
        endcase
    endfunction

    task automatic add_pair(input logic [31:0] a, input logic [31:0] b, input logic [31:0] yy, input logic [3:0] ff);
        sa[n] = a; sb[n] = b; ey[n] = yy; ef[n] = ff; sv[n] = 1'b1;
        n++;
    endtask

    task automatic add_rand(input logic [31:0] a, input logic [31:0] b);
        logic [35:0] m;
        m = model(a, b);
        add_pair(a, b, m[31:0], m[35:32]);
    endtask

    task automatic add_gap();
        sa[n] = 32'd0; sb[n] = 32'd0; ey[n] = 32'd0; ef[n] = 4'd0; sv[n] = 1'b0;
        n++;
    endtask

    // Plays the queued pairs one per cycle and checks every output every cycle.
    task automatic run(input int rst_at, input int over_at);
        for (int i = 0; i < n + L + 2; i++) begin
            int   j;
            logic ev;
            j = i - L;
            @(negedge clk);
            ev = (j >= 0) && (j < n) && sv[j] && (rst_at < 0 || i <= rst_at);
            if (rst_at >= 0 && i == rst_at + 1) begin
                hold_y = 32'd0;
                hold_f = 4'd0;
                ov_exp = 1'b0;
            end
            if (ev) begin
                hold_y = ey[j];
                hold_f = ef[j];
            end
            if (over_at >= 0 && i == over_at + L) ov_exp = 1'b1;
            chk("out_val", i, {31'd0, out_val}, {31'd0, ev});
            chk("y", i, y, hold_y);
            chk("flags", i, {28'd0, f_invalid, f_ovf, f_unf, f_inexact}, {28'd0, hold_f});
            chk("out_over", i, {31'd0, out_over}, {31'd0, ov_exp});
            if (i < n) begin
                x1 = sa[i]; x2 = sb[i]; val = sv[i];
            end else begin
                x1 = 32'd0; x2 = 32'd0; val = 1'b0;
            end
            rst = (rst_at >= 0 && i >= rst_at && i < rst_at + 3);
            if (over_at >= 0 && i >= over_at) over = 1'b1;
        end
        rst = 1'b0;
        n = 0;
    endtask

    initial begin
        rst = 1'b1; val = 1'b0; over = 1'b0; x1 = 32'd0; x2 = 32'd0;
        hold_y = 32'd0; hold_f = 4'd0; ov_exp = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_val", 0, {31'd0, out_val}, 32'd0);
        chk("rst_y", 0, y, 32'd0);
        chk("rst_flags", 0, {28'd0, f_invalid, f_ovf, f_unf, f_inexact}, 32'd0);
        chk("rst_out_over", 0, {31'd0, out_over}, 32'd0);
        rst = 1'b0;

        // Directed values, with a few val gaps
        add_pair(32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000);
        add_gap();
        add_pair(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
        add_pair(32'h3F800001, 32'h3F800000, 32'h3F800001, 4'b0000);
        add_pair(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 4'b0001);
        add_pair(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
        add_pair(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);
        add_gap();
        add_gap();
        add_pair(32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101);
        add_pair(32'hFF7FFFFF, 32'h40000000, 32'hFF800000, 4'b0101);
        add_pair(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011);
        add_pair(32'h80800000, 32'h00800000, 32'h80000000, 4'b0011);
        add_pair(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000);
        add_pair(32'h3F800000, 32'h00800000, 32'h00800000, 4'b0000);
        add_gap();
        add_pair(32'h7F800000, 32'h00000000, QN,           4'b1000);
        add_pair(32'h00000000, 32'h7F800000, QN,           4'b1000);
        add_pair(32'h7F800000, 32'h80000001, QN,           4'b1000);
        add_pair(32'h7FA00000, 32'h3F800000, QN,           4'b1000);
        add_pair(32'h7FC00001, 32'h3F800000, QN,           4'b0000);
        add_pair(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000);
        add_pair(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000);
        run(-1, -1);

        // Eight back-to-back random normals
        for (int k = 0; k < 8; k++) add_rand(rnd_normal(64, 190), rnd_normal(64, 190));
        run(-1, -1);

        // Same, with reset in the middle of the burst
        for (int k = 0; k < 8; k++) add_rand(rnd_normal(64, 190), rnd_normal(64, 190));
        run(5, -1);

        // Mixed operand classes with random val gaps
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(3, 0) == 0) add_gap();
            else add_rand(rnd_any(), rnd_any());
        end
        run(-1, -1);

        // End-of-run marker arriving with the last pair
        for (int k = 0; k < 8; k++) add_rand(rnd_normal(1, 254), rnd_normal(64, 190));
        run(-1, 7);

        // out_over stays set once raised, until reset
        over = 1'b0;
        repeat (3) @(negedge clk);
        chk("over_sticky", 0, {31'd0, out_over}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("over_cleared", 0, {31'd0, out_over}, 32'd0);
        chk("y_cleared", 0, y, 32'd0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
